// File: rtl/n_bit_serial_subtractor.sv
// -----------------------------------------------------------------------------
// n_bit_serial_subtractor
//   Bit-serial N-bit subtractor: out = in1 - in2 - ib, computed LSB first, one
//   bit per clock, with a single borrow flip-flop.
//   A start/busy/done handshake lets a controller trade latency for area
//   against the parallel datapath. The result and flags are registered and held
//   until the next operation completes.
//
//   Optional build macro: SERIAL_ADD_MODE_EN
//     When defined, a 'mode' input is added and captured with start.
//     mode=1 selects addition: ib is the carry-in and ob is the carry-out.
//     mode=0 subtracts, exactly as in the default build.
//
// Parameters
//   N   operand/result width (N >= 2)
//   CW  bit-counter width (2**CW > N)
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   operation request, sampled only in IDLE
//   in1    in   minuend, captured on accepted start
//   in2    in   subtrahend, captured on accepted start
//   ib     in   borrow-in (carry-in in add mode), captured on accepted start
//   mode   in   (SERIAL_ADD_MODE_EN only) 1 = add, 0 = subtract
//   busy   out  high in RUN and DONE
//   done   out  one-cycle pulse; result valid
//   out    out  registered difference
//   ob     out  final borrow-out (carry-out in add mode)
//   ov     out  signed two's-complement overflow
// -----------------------------------------------------------------------------
module n_bit_serial_subtractor #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         ib,
`ifdef SERIAL_ADD_MODE_EN
  input  logic         mode,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out,
  output logic         ob,
  output logic         ov
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  // Holds the N-1 result bits produced so far; the last bit goes straight
  // to the output register, so R never needs a full N bits.
  logic [N-2:0]  r_q, r_d;
  logic          borrow_q, borrow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_msb_q, a_msb_d;
  logic          b_msb_q, b_msb_d;
  logic [N-1:0]  out_q, out_d;
  logic          ob_q, ob_d;
  logic          ov_q, ov_d;
  logic          add_mode;

`ifdef SERIAL_ADD_MODE_EN
  logic          mode_q, mode_d;
  assign add_mode = mode_q;
`else
  assign add_mode = 1'b0;
`endif

  // Serial bit-slice
  logic         bit_a, bit_b, d_bit;
  logic         borrow_sub, carry_add;
  logic         ov_sub, ov_add;
  logic [N-1:0] r_shift;

  assign bit_a      = a_q[0];
  assign bit_b      = b_q[0];
  assign d_bit      = bit_a ^ bit_b ^ borrow_q;
  assign borrow_sub = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
  assign carry_add  = (bit_a & bit_b) | (bit_a & borrow_q) | (bit_b & borrow_q);
  assign r_shift    = {d_bit, r_q};
  // On the last bit d_bit is the result MSB.
  assign ov_sub     = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
  assign ov_add     = ~(a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    out_d    = out_q;
    ob_d     = ob_q;
    ov_d     = ov_q;
`ifdef SERIAL_ADD_MODE_EN
    mode_d   = mode_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = in1;
          b_d      = in2;
          a_msb_d  = in1[N-1];
          b_msb_d  = in2[N-1];
          borrow_d = ib;
          cnt_d    = '0;
`ifdef SERIAL_ADD_MODE_EN
          mode_d   = mode;
`endif
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_d      = {1'b0, a_q[N-1:1]};
        b_d      = {1'b0, b_q[N-1:1]};
        r_d      = r_shift[N-1:1];
        borrow_d = add_mode ? carry_add : borrow_sub;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          out_d   = r_shift;
          ob_d    = borrow_d;
          ov_d    = add_mode ? ov_add : ov_sub;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      out_q    <= '0;
      ob_q     <= 1'b0;
      ov_q     <= 1'b0;
`ifdef SERIAL_ADD_MODE_EN
      mode_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      out_q    <= out_d;
      ob_q     <= ob_d;
      ov_q     <= ov_d;
`ifdef SERIAL_ADD_MODE_EN
      mode_q   <= mode_d;
`endif
    end
  end

  // Moore outputs decoded from registered state
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign out  = out_q;
  assign ob   = ob_q;
  assign ov   = ov_q;

endmodule

// File: tb/tb_n_bit_serial_subtractor.sv
module tb_n_bit_serial_subtractor;
  localparam int N  = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] in1, in2;
  logic         ib;
  logic         mode;
  logic         busy, done;
  logic [N-1:0] out;
  logic         ob, ov;

  n_bit_serial_subtractor #(.N(N), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .ib    (ib),
`ifdef SERIAL_ADD_MODE_EN
    .mode  (mode),
`endif
    .busy  (busy),
    .done  (done),
    .out   (out),
    .ob    (ob),
    .ov    (ov)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] out;
    logic         ob;
    logic         ov;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  logic [N-1:0] prev_out = '0;
  logic         prev_ob  = 1'b0;
  logic         prev_ov  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: whole-word arithmetic, independent of the serial datapath.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic c, input logic add);
    exp_t       e;
    logic [N:0] r;
    if (add) begin
      r    = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
      e.ov = ~(a[N-1] ^ b[N-1]) & (a[N-1] ^ r[N-1]);
    end else begin
      r    = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, c};
      e.ov = (a[N-1] ^ b[N-1]) & (a[N-1] ^ r[N-1]);
    end
    e.out = r[N-1:0];
    e.ob  = r[N];
    return e;
  endfunction

  // One complete operation; 'inject' re-asserts start with other operands
  // during RUN (cycle 2) and DONE (cycle 5), which must be ignored.
  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic c, input logic md, input bit inject);
    exp_t e;
    int   k;
    bit   seen;
    @(negedge clk);
    start = 1'b1; in1 = a; in2 = b; ib = c; mode = md;
    sb.push_back(model(a, b, c, md));
    @(negedge clk);
    seen = 1'b0;
    for (k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      check({name, "_busy"}, busy, 1'b1);
      if (inject && (k == 1 || k == 4)) begin
        start = 1'b1; in1 = ~a; in2 = a; ib = ~c; mode = ~md;
      end else begin
        start = 1'b0; in1 = N'($urandom); in2 = N'($urandom);
        ib = 1'($urandom); mode = 1'($urandom);
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      check({name, "_out_hold"}, out, prev_out);
      check({name, "_ob_hold"},  ob,  prev_ob);
    end
    check({name, "_done_seen"}, seen, 1'b1);
    check({name, "_latency"}, k, N);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_out"}, out, e.out);
      check({name, "_ob"},  ob,  e.ob);
      check({name, "_ov"},  ov,  e.ov);
      prev_out = e.out; prev_ob = e.ob; prev_ov = e.ov;
    end else begin
      sb.delete();
    end
    @(negedge clk);
    start = 1'b0;
    check({name, "_done_pulse"}, done, 1'b0);
    check({name, "_idle_busy"},  busy, 1'b0);
    check({name, "_idle_out"},   out,  prev_out);
    check({name, "_idle_ov"},    ov,   prev_ov);
    $display("[TB] %s in1=%b in2=%b ib=%b mode=%b -> out=%b ob=%b ov=%b",
             name, a, b, c, md, out, ob, ov);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; ib = 1'b0; mode = 1'b0;
    #1;
    check("rst_out",  out,  '0);
    check("rst_ob",   ob,   1'b0);
    check("rst_ov",   ov,   1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    // start low keeps the block idle
    @(negedge clk);
    check("idle_no_start", busy, 1'b0);

    run_op("t1",      4'b1010, 4'b1001, 1'b0, 1'b0, 1'b0);
    run_op("t2",      4'b0111, 4'b1000, 1'b0, 1'b0, 1'b0);
    run_op("t3",      4'b1001, 4'b1010, 1'b0, 1'b0, 1'b0);
    run_op("t4_ib",   4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    run_op("t5",      4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    run_op("t6_inj",  4'b0011, 4'b0101, 1'b0, 1'b0, 1'b1);
    run_op("t7",      4'b1000, 4'b0001, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in RUN cycle 2 aborts the operation.
    @(negedge clk);
    start = 1'b1; in1 = 4'b0111; in2 = 4'b1000; ib = 1'b0; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_pre", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_out",  out,  '0);
    check("abort_ob",   ob,   1'b0);
    check("abort_ov",   ov,   1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    prev_out = '0; prev_ob = 1'b0; prev_ov = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    $display("[TB] abort: reset in RUN cycle 2 -> out=%b busy=%b", out, busy);
    run_op("t8_post", 4'b0110, 4'b0011, 1'b1, 1'b0, 1'b0);

`ifdef SERIAL_ADD_MODE_EN
    run_op("t9_add",  4'b1010, 4'b1001, 1'b0, 1'b1, 1'b0);
    run_op("t10_sub", 4'b1010, 4'b1001, 1'b0, 1'b0, 1'b0);
    run_op("t11_add", 4'b0111, 4'b0001, 1'b1, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 6; i++) begin
      run_op("rand", N'($urandom), N'($urandom), 1'($urandom), 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
